// File: rtl/counter_up_pkg.sv
// -----------------------------------------------------------------------------
// counter_up_pkg
// Shared defaults and parameter legality checks for the counter_up block.
//   COUNTER_UP_DEFAULT_WIDTH : default counter width in bits
//   COUNTER_UP_DEFAULT_STEP  : default increment per cycle
//   counter_up_params_ok()   : constant function, true for a legal
//                              WIDTH / MAX_COUNT / STEP combination
// -----------------------------------------------------------------------------
package counter_up_pkg;

  localparam int COUNTER_UP_DEFAULT_WIDTH = 4;
  localparam int COUNTER_UP_DEFAULT_STEP  = 1;

  function automatic bit counter_up_width_ok(input int width);
    return (width >= 2) && (width <= 32);
  endfunction

  // The terminal value must be reachable in WIDTH bits and non-zero.
  function automatic bit counter_up_max_ok(input int width, input longint max_count);
    return (max_count >= 1) && (max_count <= ((longint'(1) << width) - 1));
  endfunction

  function automatic bit counter_up_step_ok(input longint step, input longint max_count);
    return (step >= 1) && (step <= max_count);
  endfunction

  function automatic bit counter_up_params_ok(input int width, input longint max_count,
                                              input longint step);
    return counter_up_width_ok(width) &&
           counter_up_max_ok(width, max_count) &&
           counter_up_step_ok(step, max_count);
  endfunction

endpackage

// File: rtl/counter_up_next.sv
// -----------------------------------------------------------------------------
// counter_up_next
// Purely combinational next-count computation for counter_up.
//   q       : current count
//   q_next  : count after one step, wrapped modulo MAX_COUNT+1
//   wrapped : (only with COUNTER_UP_WRAP_FLAG_EN) high when this step wraps
// The sum is formed at WIDTH+1 bits so the carry out of a full-range
// counter (MAX_COUNT = 2**WIDTH-1) takes part in the wrap decision.
// -----------------------------------------------------------------------------
module counter_up_next
  import counter_up_pkg::*;
#(
  parameter int     WIDTH     = COUNTER_UP_DEFAULT_WIDTH,
  parameter longint MAX_COUNT = (longint'(1) << WIDTH) - 1,
  parameter longint STEP      = COUNTER_UP_DEFAULT_STEP
) (
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_next
`ifdef COUNTER_UP_WRAP_FLAG_EN
  ,
  output logic             wrapped
`endif
);

  localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] MOD_EXT  = MAX_EXT + (WIDTH+1)'(1);

  logic [WIDTH:0] sum;
  logic           wrap_cond;

  assign sum       = {1'b0, q} + STEP_EXT;
  assign wrap_cond = (sum > MAX_EXT);

  // On wrap the remainder past the terminal value carries into the new lap.
  always_comb begin
    q_next = sum[WIDTH-1:0];
    if (wrap_cond) begin
      q_next = WIDTH'(sum - MOD_EXT);
    end
  end

`ifdef COUNTER_UP_WRAP_FLAG_EN
  assign wrapped = wrap_cond;
`endif

endmodule

// File: rtl/counter_up.sv
// -----------------------------------------------------------------------------
// counter_up
// Free-running modulo (MAX_COUNT+1) up-counter advancing by STEP every cycle.
//   clk     : clock, rising edge
//   reset_n : asynchronous reset, ACTIVE HIGH despite its name
//   q       : current count, registered
//   tc      : terminal count, high while q == MAX_COUNT (combinational)
//   wrap    : (only with COUNTER_UP_WRAP_FLAG_EN) one-cycle registered pulse
//             following an edge on which q wrapped
// Optional feature macro: COUNTER_UP_WRAP_FLAG_EN
// -----------------------------------------------------------------------------
module counter_up
  import counter_up_pkg::*;
#(
  parameter int     WIDTH     = COUNTER_UP_DEFAULT_WIDTH,
  parameter longint MAX_COUNT = (longint'(1) << WIDTH) - 1,
  parameter longint STEP      = COUNTER_UP_DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [WIDTH-1:0] q,
  output logic             tc
`ifdef COUNTER_UP_WRAP_FLAG_EN
  ,
  output logic             wrap
`endif
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  if (!counter_up_params_ok(WIDTH, MAX_COUNT, STEP)) begin : g_param_err
    $error("counter_up: illegal parameters WIDTH=%0d MAX_COUNT=%0d STEP=%0d",
           WIDTH, MAX_COUNT, STEP);
  end

  logic [WIDTH-1:0] q_next;

`ifdef COUNTER_UP_WRAP_FLAG_EN
  logic wrapped;

  counter_up_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .STEP      (STEP)
  ) u_next (
    .q       (q),
    .q_next  (q_next),
    .wrapped (wrapped)
  );
`else
  counter_up_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT),
    .STEP      (STEP)
  ) u_next (
    .q      (q),
    .q_next (q_next)
  );
`endif

  // ---- register stage: count (and wrap flag) ----
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

`ifdef COUNTER_UP_WRAP_FLAG_EN
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrapped;
    end
  end
`endif

  // q is 0 in reset and MAX_COUNT >= 1, so tc is low in reset.
  assign tc = (q == MAX_Q);

endmodule

// File: tb/tb_counter_up.sv
// -----------------------------------------------------------------------------
// tb_counter_up
// Three counter_up instances (defaults; MAX_COUNT=9 STEP=1; MAX_COUNT=9
// STEP=4) share clock and reset. The stimulus process drives reset and pushes
// the expected outputs of every instance into a queue; the monitor pops and
// compares on each falling edge and right after every asynchronous reset.
// Expected values come from the edge count since reset: q = n*STEP mod (MAX+1).
// Optional feature macro: COUNTER_UP_WRAP_FLAG_EN
// -----------------------------------------------------------------------------
module tb_counter_up;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] q_a, q_b, q_c;
  logic       tc_a, tc_b, tc_c;
`ifdef COUNTER_UP_WRAP_FLAG_EN
  logic       wrap_a, wrap_b, wrap_c;
`endif

  always #5 clk = ~clk;

`ifdef COUNTER_UP_WRAP_FLAG_EN
  counter_up #(.WIDTH(4)) dut_a (.clk(clk), .reset_n(reset_n), .q(q_a), .tc(tc_a), .wrap(wrap_a));
  counter_up #(.WIDTH(4), .MAX_COUNT(9), .STEP(1)) dut_b (.clk(clk), .reset_n(reset_n), .q(q_b), .tc(tc_b), .wrap(wrap_b));
  counter_up #(.WIDTH(4), .MAX_COUNT(9), .STEP(4)) dut_c (.clk(clk), .reset_n(reset_n), .q(q_c), .tc(tc_c), .wrap(wrap_c));
`else
  counter_up #(.WIDTH(4)) dut_a (.clk(clk), .reset_n(reset_n), .q(q_a), .tc(tc_a));
  counter_up #(.WIDTH(4), .MAX_COUNT(9), .STEP(1)) dut_b (.clk(clk), .reset_n(reset_n), .q(q_b), .tc(tc_b));
  counter_up #(.WIDTH(4), .MAX_COUNT(9), .STEP(4)) dut_c (.clk(clk), .reset_n(reset_n), .q(q_c), .tc(tc_c));
`endif

  typedef struct {
    int dut;
    int q;
    bit tc;
    bit wr;
  } exp_t;

  exp_t   exp_q[$];
  longint cfg_max  [3] = '{15, 9, 9};
  longint cfg_step [3] = '{1, 1, 4};
  int     n = 0;          // rising edges seen since reset was last released
  int     chk_cnt  = 0;
  int     pass_cnt = 0;
  bit     stim_done = 1'b0;
  event   async_chk;

  function automatic int model_q(input int i, input int edges);
    return int'((longint'(edges) * cfg_step[i]) % (cfg_max[i] + 1));
  endfunction

  // A wrap happened on the last edge if the lap number advanced.
  function automatic bit model_wrap(input int i, input int edges);
    if (edges == 0) return 1'b0;
    return ((longint'(edges) * cfg_step[i]) / (cfg_max[i] + 1)) !=
           ((longint'(edges - 1) * cfg_step[i]) / (cfg_max[i] + 1));
  endfunction

  task automatic push_all();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.dut = i;
      e.q   = model_q(i, n);
      e.tc  = (longint'(e.q) == cfg_max[i]);
      e.wr  = (reset_n == 1'b0) && model_wrap(i, n);
      exp_q.push_back(e);
    end
  endtask

  // Advance one rising edge and record what every instance must show.
  task automatic step();
    @(posedge clk);
    #1;
    if (reset_n == 1'b0) n++;
    push_all();
  endtask

  // Assert reset between edges and expect q = 0 without any clock edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b1;
    n = 0;
    #1;
    push_all();
    ->async_chk;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    chk_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: compares every pending expectation against the live outputs.
  initial begin
    exp_t e;
    int   aq;
    bit   at;
    bit   aw;
    forever begin
      @(negedge clk or async_chk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        aw = 1'b0;
        case (e.dut)
          0: begin
            aq = int'(q_a); at = tc_a;
`ifdef COUNTER_UP_WRAP_FLAG_EN
            aw = wrap_a;
`endif
          end
          1: begin
            aq = int'(q_b); at = tc_b;
`ifdef COUNTER_UP_WRAP_FLAG_EN
            aw = wrap_b;
`endif
          end
          default: begin
            aq = int'(q_c); at = tc_c;
`ifdef COUNTER_UP_WRAP_FLAG_EN
            aw = wrap_c;
`endif
          end
        endcase
        check($sformatf("dut%0d q", e.dut), aq, e.q);
        check($sformatf("dut%0d tc", e.dut), int'(at), int'(e.tc));
`ifdef COUNTER_UP_WRAP_FLAG_EN
        check($sformatf("dut%0d wrap", e.dut), int'(aw), int'(e.wr));
`else
        if (aw != e.wr) begin
          // wrap output absent in this build; the model value is not compared
        end
`endif
      end
    end
  end

  // Stimulus
  initial begin
    // Power-on reset held for 10 time units, spanning one rising edge.
    #1;
    reset_n = 1'b1;
    #2;
    push_all();
    ->async_chk;
    step();
    release_reset();

    // Count from 0: 1 after the first edge, 10 after ten, full wrap at 16.
    for (int k = 0; k < 22; k++) step();

    // Default counter now sits at 6; reset it mid-count.
    async_reset();
    step();
    release_reset();
    for (int k = 0; k < 12; k++) step();

    // Randomized resets interleaved with counting.
    for (int k = 0; k < 300; k++) begin
      step();
      if (reset_n == 1'b1) begin
        if ($urandom_range(1, 0) == 1) release_reset();
      end else if ($urandom_range(19, 0) == 0) begin
        async_reset();
      end
    end
    if (reset_n == 1'b1) release_reset();
    for (int k = 0; k < 20; k++) step();

    @(negedge clk);
    #1;
    stim_done = 1'b1;
  end

  // Finish: drain check plus a hard time bound.
  initial begin
    fork
      wait (stim_done == 1'b1);
      #100000;
    join_any
    disable fork;
    if (stim_done == 1'b0) check("time budget", 0, 1);
    check("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/counter_up.md
COUNTER_UP -- requirements
Module: counter_up

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter MAX_COUNT, default 2**WIDTH-1: terminal value before wrap, legal range 1..2**WIDTH-1.
REQ-003 SHALL have parameter STEP, default 1: increment per enabled cycle, legal range 1..MAX_COUNT.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-high reset (asserted = 1, despite the port name).
REQ-006 SHALL have port q, output, WIDTH bits: current count, driven directly from a register.
REQ-007 SHALL have port tc, output, 1 bit: terminal count, combinational, high while q == MAX_COUNT.

Function
REQ-008 SHALL, while reset is deasserted, update q on every rising clk edge; no enable input, counts every cycle.
REQ-009 SHALL update q to q+STEP when q+STEP <= MAX_COUNT.
REQ-010 SHALL otherwise wrap q to (q+STEP) - (MAX_COUNT+1), modulo count MAX_COUNT+1; for STEP=1 this gives MAX_COUNT -> 0.
REQ-011 SHALL compute the sum at WIDTH+1 bits so the overflow at MAX_COUNT = 2**WIDTH-1 cannot be lost.
REQ-012 SHALL have a latency of one cycle: the new q is visible after the edge that computes it.
REQ-013 SHALL show the first increment (0 -> STEP) on the first rising edge after reset deasserts.
REQ-014 SHALL never drive q above MAX_COUNT.

Reset
REQ-015 SHALL, on reset_n = 1, force q to 0 immediately with no clock edge required, and hold it at 0 while asserted.
REQ-016 SHALL drive tc low during reset, unless MAX_COUNT is 0, which is illegal.
REQ-017 SHALL treat reset asserted mid-count the same way: the count is discarded and restarts from 0.
REQ-018 SHALL, when reset and a clk edge coincide, give reset priority.

Configuration
REQ-019 SHALL, with macro COUNTER_UP_WRAP_FLAG_EN defined, add output wrap (1 bit, registered), high for exactly the one cycle following an edge on which q wrapped; 0 in reset.
REQ-020 SHALL, without COUNTER_UP_WRAP_FLAG_EN, omit the wrap port and its register entirely; q and tc behaviour is identical in both builds.

Structure
REQ-021 SHALL place the defaults in shared package counter_up_pkg: COUNTER_UP_DEFAULT_WIDTH = 4 and COUNTER_UP_DEFAULT_STEP = 1.
REQ-022 SHALL place the parameter legality checks in counter_up_pkg as constant functions.
REQ-023 SHALL implement next-value and wrap computation in sub-module counter_up_next, which is purely combinational.
REQ-024 SHALL hold the register and reset logic in counter_up.
REQ-025 SHALL flag an illegal parameter combination with an elaboration-time error.

Verification
REQ-026 SHALL cover reset: reset_n = 1 for 10 time units -> q = 0000, tc = 0; after release, q = 0001 after the first edge and 1010 after 10 edges.
REQ-027 SHALL cover wrap at defaults: 16 edges from 0 -> q passes 1111 with tc = 1, then returns to 0000.
REQ-028 SHALL cover mid-count reset: at q = 0110, assert reset_n between clock edges -> q = 0000 before the next edge; after release, counting resumes 0001, 0010, ...
REQ-029 SHALL cover MAX_COUNT = 9, STEP = 1: sequence 0..9, 0; tc high only at 9.
REQ-030 SHALL cover MAX_COUNT = 9, STEP = 4: sequence 0, 4, 8, 2, 6, 0.
REQ-031 SHALL cover COUNTER_UP_WRAP_FLAG_EN at defaults: wrap pulses high for one cycle, coincident with q = 0000 after 1111, and is otherwise 0.
